// File: rtl/rr_slice_pkg.sv
// Shared types and the round-robin pick function for the time-sliced arbiter.
package rr_slice_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_SLICE = 8;
    localparam int MAX_REQ   = 8;
    localparam int MAX_ID_W  = 3;
    localparam int MAX_CNT_W = 16;

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_e;

    typedef struct packed {
        logic [MAX_CNT_W-1:0] count;
        logic                 ovf;
    } slice_cnt_t;

    // First set bit of req searching upward from last+1, wrapping at n.
    // Returns last unchanged when req is empty.
    function automatic logic [MAX_ID_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0]  req,
        input int unsigned         n,
        input logic [MAX_ID_W-1:0] last
    );
        logic [MAX_ID_W-1:0] win;
        logic                found;
        int unsigned         idx;
        win   = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            idx = 32'(last) + i;
            if (idx >= n) idx = idx - n;
            if (!found && i <= n && req[idx[MAX_ID_W-1:0]]) begin
                win   = idx[MAX_ID_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_slice_arbiter_slice_cntr.sv
// Mod-(MAXCNT+1) slice counter with synchronous clear (priority) and enable.
module slice_cntr
    import rr_slice_pkg::*;
#(
    parameter int MAXCNT = DEF_SLICE - 1,
    parameter int CNT_W  = $clog2(MAXCNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enb,
    input  logic             i_clr,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_count
);

    slice_cnt_t cnt_q;
    slice_cnt_t cnt_d;

    // ovf is kept registered alongside the count so it is glitch-free for the FSM.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d.count = '0;
        end else if (i_enb) begin
            cnt_d.count = cnt_q.ovf ? '0 : cnt_q.count + MAX_CNT_W'(1);
        end
        cnt_d.ovf = (cnt_d.count == MAX_CNT_W'(MAXCNT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_ovf   = cnt_q.ovf;
    assign o_count = cnt_q.count[CNT_W-1:0];

endmodule

// File: rtl/rr_slice_arbiter.sv
// Time-sliced round-robin arbiter: one owner at a time, preempted on slice
// expiry when others wait, with a one-cycle GAP between owners.
module rr_slice_arbiter
    import rr_slice_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int SLICE = DEF_SLICE,
    parameter int ID_W  = $clog2(N_REQ),
    parameter int CNT_W = $clog2(SLICE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_release,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_gnt_id,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_slice_cnt,
    output logic             o_preempt
);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic             pre_q, pre_d;
    logic             cnt_enb, cnt_clr, cnt_ovf;
    logic [ID_W-1:0]  win;
    logic [N_REQ-1:0] own_mask;
    logic             others;

    slice_cntr #(
        .MAXCNT(SLICE - 1),
        .CNT_W (CNT_W)
    ) u_slice_cntr (
        .clk    (clk),
        .rst    (rst),
        .i_enb  (cnt_enb),
        .i_clr  (cnt_clr),
        .o_ovf  (cnt_ovf),
        .o_count(o_slice_cnt)
    );

    assign win      = ID_W'(rr_pick(MAX_REQ'(i_req), N_REQ, MAX_ID_W'(last_q)));
    assign own_mask = N_REQ'(1) << gnt_id_q;
    assign others   = |(i_req & ~own_mask);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        last_d   = last_q;
        pre_d    = 1'b0;
        cnt_enb  = 1'b0;
        cnt_clr  = 1'b0;
        case (state_q)
            IDLE, GAP: begin
                gnt_d   = '0;
                state_d = IDLE;
                if (|i_req) begin
                    state_d  = OWN;
                    gnt_d    = N_REQ'(1) << win;
                    gnt_id_d = win;
                    last_d   = win;
                    cnt_clr  = 1'b1;
                end
            end
            OWN: begin
                cnt_enb = 1'b1;
                // Release beats expiry, so a simultaneous release never flags preemption.
                if (i_release || !i_req[gnt_id_q]) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    cnt_clr = 1'b1;
                end else if (cnt_ovf && others) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    cnt_clr = 1'b1;
                    pre_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            last_q   <= ID_W'(N_REQ - 1);
            pre_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            last_q   <= last_d;
            pre_q    <= pre_d;
        end
    end

    assign o_gnt     = gnt_q;
    assign o_gnt_id  = gnt_id_q;
    assign o_busy    = (state_q == OWN);
    assign o_preempt = pre_q;

endmodule

// File: tb/tb_rr_slice_arbiter.sv
// Directed bench for rr_slice_arbiter with a per-cycle behavioural model.
module tb_rr_slice_arbiter;

    localparam int N_REQ = 4;
    localparam int SLICE = 8;
    localparam int ID_W  = 2;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N_REQ-1:0] i_req = '0;
    logic             i_release = 1'b0;
    logic [N_REQ-1:0] o_gnt;
    logic [ID_W-1:0]  o_gnt_id;
    logic             o_busy;
    logic [CNT_W-1:0] o_slice_cnt;
    logic             o_preempt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // model: owner index (-1 = nobody holds the resource), pointer, count, pulse
    int m_owner = -1;
    int m_last  = N_REQ - 1;
    int m_id    = 0;
    int m_cnt   = 0;
    bit m_pre   = 1'b0;

    logic [ID_W-1:0] exp_q[$];

    rr_slice_arbiter #(.N_REQ(N_REQ), .SLICE(SLICE)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_release  (i_release),
        .o_gnt      (o_gnt),
        .o_gnt_id   (o_gnt_id),
        .o_busy     (o_busy),
        .o_slice_cnt(o_slice_cnt),
        .o_preempt  (o_preempt)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        i_req = '0;
        i_release = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive(input logic [N_REQ-1:0] r, input logic rel);
        @(negedge clk);
        i_req = r;
        i_release = rel;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: an owner keeps the slot until it leaves or its slice
    // expires with someone else waiting; any ownerless cycle picks round-robin.
    always @(posedge clk or posedge rst) begin : model
        int o, l, id, c, idx;
        bit p;
        if (rst) begin
            m_owner <= -1;
            m_last  <= N_REQ - 1;
            m_id    <= 0;
            m_cnt   <= 0;
            m_pre   <= 1'b0;
        end else begin
            o = m_owner; l = m_last; id = m_id; c = m_cnt; p = 1'b0;
            if (o >= 0) begin
                if (i_release || !i_req[o]) begin
                    o = -1; c = 0;
                end else if (c == SLICE - 1 && (i_req & ~(4'b0001 << o)) != 0) begin
                    o = -1; c = 0; p = 1'b1;
                end else begin
                    c = (c + 1) % SLICE;
                end
            end else if (i_req != 0) begin
                for (int k = 1; k <= N_REQ; k++) begin
                    idx = (m_last + k) % N_REQ;
                    if (o < 0 && i_req[idx]) begin
                        o = idx; l = idx; id = idx; c = 0;
                    end
                end
            end
            m_owner <= o; m_last <= l; m_id <= id; m_cnt <= c; m_pre <= p;
        end
    end

    // compare process
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("m_gnt", 32'(o_gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("m_gnt_id", 32'(o_gnt_id), 32'(m_id));
            chk("m_busy", 32'(o_busy), (m_owner >= 0) ? 32'd1 : 32'd0);
            chk("m_cnt", 32'(o_slice_cnt), 32'(m_cnt));
            chk("m_preempt", 32'(o_preempt), 32'(m_pre));
            chk("onehot", 32'((o_gnt & (o_gnt - 4'd1)) == 4'd0), 32'd1);
            chk("gnt_not_busy", 32'(!o_busy && o_gnt != 4'd0), 32'd0);
        end
    end

    initial begin
        logic [N_REQ-1:0] eg, prev;
        logic             ep;
        logic [ID_W-1:0]  e_id;

        do_reset();
        chk("rst_gnt", 32'(o_gnt), 32'd0);
        chk("rst_id", 32'(o_gnt_id), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_cnt", 32'(o_slice_cnt), 32'd0);
        chk("rst_pre", 32'(o_preempt), 32'd0);
        cmp_en = 1'b1;

        // single requester keeps its grant across slice wrap
        drive(4'b0100, 1'b0);
        for (int k = 0; k <= 9; k++) begin
            @(negedge clk);
            chk("t1_gnt", 32'(o_gnt), 32'h4);
            chk("t1_cnt", 32'(o_slice_cnt), 32'(k % 8));
            chk("t1_pre", 32'(o_preempt), 32'd0);
        end
        chk("t1_id", 32'(o_gnt_id), 32'd2);
        drive(4'b0000, 1'b0);
        repeat (3) @(negedge clk);

        // two-way contention with preemption
        do_reset();
        drive(4'b0011, 1'b0);
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            eg = (i < 8) ? 4'b0001 : (i == 8) ? 4'b0000 : (i < 17) ? 4'b0010 :
                 (i == 17) ? 4'b0000 : 4'b0001;
            ep = (i == 8 || i == 17);
            chk("t2_gnt", 32'(o_gnt), 32'(eg));
            chk("t2_pre", 32'(o_preempt), 32'(ep));
        end

        // early release at count 3
        do_reset();
        drive(4'b1001, 1'b0);
        repeat (4) @(negedge clk);
        chk("t3_cnt", 32'(o_slice_cnt), 32'd3);
        chk("t3_gnt0", 32'(o_gnt), 32'h1);
        i_release = 1'b1;
        @(negedge clk);
        i_release = 1'b0;
        chk("t3_gap_gnt", 32'(o_gnt), 32'd0);
        chk("t3_gap_pre", 32'(o_preempt), 32'd0);
        chk("t3_gap_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        chk("t3_gnt3", 32'(o_gnt), 32'h8);
        chk("t3_id3", 32'(o_gnt_id), 32'd3);

        // release coinciding with expiry
        do_reset();
        drive(4'b0011, 1'b0);
        repeat (8) @(negedge clk);
        chk("t4_cnt", 32'(o_slice_cnt), 32'd7);
        i_release = 1'b1;
        @(negedge clk);
        i_release = 1'b0;
        chk("t4_gap_gnt", 32'(o_gnt), 32'd0);
        chk("t4_gap_pre", 32'(o_preempt), 32'd0);
        @(negedge clk);
        chk("t4_gnt1", 32'(o_gnt), 32'h2);

        // asynchronous reset mid-grant
        do_reset();
        drive(4'b0011, 1'b0);
        repeat (15) @(negedge clk);
        chk("t5_gnt", 32'(o_gnt), 32'h2);
        chk("t5_cnt", 32'(o_slice_cnt), 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_gnt", 32'(o_gnt), 32'd0);
        chk("t5_rst_id", 32'(o_gnt_id), 32'd0);
        chk("t5_rst_busy", 32'(o_busy), 32'd0);
        chk("t5_rst_cnt", 32'(o_slice_cnt), 32'd0);
        chk("t5_rst_pre", 32'(o_preempt), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        i_req = 4'b1111;
        @(negedge clk);
        chk("t5_after_gnt", 32'(o_gnt), 32'h1);

        // fairness with all four requesting; grant order on rising grants
        do_reset();
        exp_q.delete();
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        drive(4'b1111, 1'b0);
        prev = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_gnt != 4'd0 && prev == 4'd0) begin
                if (exp_q.size() == 0) begin
                    chk("t6_extra_grant", 32'(o_gnt_id), 32'hFFFF_FFFF);
                end else begin
                    e_id = exp_q.pop_front();
                    chk("t6_order", 32'(o_gnt_id), 32'(e_id));
                end
            end
            prev = o_gnt;
        end
        chk("t6_remaining", 32'(exp_q.size()), 32'd0);
        drive(4'b0000, 1'b0);
        repeat (3) @(negedge clk);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
